// File: rtl/sys_spm_pkg.sv
// rtl/sys_spm_pkg.sv - shared types and constants for the scratchpad scrubber
//
// Purpose: FSM state encoding, AXI field widths/types, the OKAY response code,
//          the INCR burst code and the default burst length used by
//          sys_spm_scrubber.
// Ports:   none (package).

package sys_spm_pkg;

  localparam int unsigned DEFAULT_BURST_LEN = 16;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W  = 2;

  typedef logic [AXI_ID_W-1:0]    axi_id_t;
  typedef logic [AXI_LEN_W-1:0]   axi_len_t;
  typedef logic [AXI_SIZE_W-1:0]  axi_size_t;
  typedef logic [AXI_BURST_W-1:0] axi_burst_t;
  typedef logic [AXI_RESP_W-1:0]  axi_resp_t;

  localparam axi_resp_t  RESP_OKAY  = 2'b00;
  localparam axi_burst_t BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_NEXT,
    ST_DONE
  } spm_state_e;

  // AxSIZE encoding for a bus of the given width in bits.
  function automatic axi_size_t axi_size_of(input int unsigned data_width);
    return axi_size_t'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/sys_spm_scrubber.sv
// rtl/sys_spm_scrubber.sv - scratchpad memory init/scrub engine (AXI manager)
//
// Purpose: sweeps i_num_bursts consecutive bursts starting at i_base_addr,
//          either writing zeros (init, i_mode=0) or reading and discarding
//          data (scrub, i_mode=1). One transaction is outstanding at a time.
//          Non-OKAY responses set a sticky error flag and record the address
//          of the first failing burst; the sweep keeps going. An abort lets
//          the in-flight burst finish and then ends the sweep.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_start, i_mode, i_abort       control: start pulse, 0=init 1=scrub, abort
//   i_base_addr, i_num_bursts      sweep start address and burst count
//   o_busy, o_done, o_aborted      status: active, completion pulse, abort flag
//   o_err, o_err_addr              sticky error flag and first-error address
//   AW/W/B/AR/R channel signals    AXI manager interface

module sys_spm_scrubber
  import sys_spm_pkg::*;
#(
  parameter int unsigned BurstLen  = DEFAULT_BURST_LEN,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 40,
  parameter int unsigned AxiId     = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,

  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic                   i_abort,
  input  logic [AddrWidth-1:0]   i_base_addr,
  input  logic [15:0]            i_num_bursts,

  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted,
  output logic                   o_err,
  output logic [AddrWidth-1:0]   o_err_addr,

  output logic [AddrWidth-1:0]   o_awaddr,
  output axi_id_t                o_awid,
  output axi_len_t               o_awlen,
  output axi_size_t              o_awsize,
  output axi_burst_t             o_awburst,
  output logic                   o_awvalid,
  input  logic                   i_awready,

  output logic [DataWidth-1:0]   o_wdata,
  output logic [DataWidth/8-1:0] o_wstrb,
  output logic                   o_wlast,
  output logic                   o_wvalid,
  input  logic                   i_wready,

  input  axi_id_t                i_bid,
  input  axi_resp_t              i_bresp,
  input  logic                   i_bvalid,
  output logic                   o_bready,

  output logic [AddrWidth-1:0]   o_araddr,
  output axi_id_t                o_arid,
  output axi_len_t               o_arlen,
  output axi_size_t              o_arsize,
  output axi_burst_t             o_arburst,
  output logic                   o_arvalid,
  input  logic                   i_arready,

  input  axi_id_t                i_rid,
  input  logic [DataWidth-1:0]   i_rdata,
  input  axi_resp_t              i_rresp,
  input  logic                   i_rlast,
  input  logic                   i_rvalid,
  output logic                   o_rready
);

  localparam int unsigned BurstBytes = BurstLen * DataWidth / 8;
  localparam logic [8:0]  LastBeat   = 9'(BurstLen - 1);

  spm_state_e           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [15:0]          count_q;
  logic [8:0]           beat_q;
  logic                 mode_q;
  logic                 abort_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 aborted_q;
  logic                 err_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 wlast_q;
  logic                 bready_q;
  logic                 arvalid_q;
  logic                 rready_q;

  logic [AddrWidth-1:0] addr_d;
  logic [15:0]          count_d;
  logic                 abort_now;
  logic                 resp_err;

  // Next-burst address wraps silently at 2^AddrWidth.
  assign addr_d    = addr_q + AddrWidth'(BurstBytes);
  assign count_d   = count_q - 16'd1;
  assign abort_now = abort_q | i_abort;

  // Bad response on any accepted B or on any accepted R beat of the burst.
  assign resp_err = (state_q == ST_B && i_bvalid && i_bresp != RESP_OKAY) ||
                    (state_q == ST_R && i_rvalid && i_rresp != RESP_OKAY);

  // IDs and read data are consumed only by the handshake, never inspected.
  logic unused_inputs;
  assign unused_inputs = ^{i_bid, i_rid, i_rdata};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Abort only takes effect at the next burst boundary.
      if (i_abort && state_q != ST_IDLE) begin
        abort_q <= 1'b1;
      end

      if (resp_err) begin
        err_q <= 1'b1;
        if (!err_q) begin
          err_addr_q <= addr_q;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            addr_q  <= i_base_addr;
            count_q <= i_num_bursts;
            mode_q  <= i_mode;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b1;
            if (i_num_bursts == 16'd0) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              aborted_q <= 1'b0;
            end else if (i_mode) begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
            end else begin
              state_q   <= ST_AW;
              awvalid_q <= 1'b1;
            end
          end
        end

        ST_AW: begin
          if (i_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            wlast_q   <= (BurstLen == 1);
            state_q   <= ST_W;
          end
        end

        ST_W: begin
          if (i_wready) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end else begin
              beat_q  <= beat_q + 9'd1;
              wlast_q <= (beat_q + 9'd1 == LastBeat);
            end
          end
        end

        ST_B: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_NEXT;
          end
        end

        ST_AR: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end

        ST_R: begin
          if (i_rvalid && i_rlast) begin
            rready_q <= 1'b0;
            state_q  <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          addr_q  <= addr_d;
          count_q <= count_d;
          if (count_q == 16'd1 || abort_now) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            aborted_q <= abort_now;
          end else if (mode_q) begin
            state_q   <= ST_AR;
            arvalid_q <= 1'b1;
          end else begin
            state_q   <= ST_AW;
            awvalid_q <= 1'b1;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_aborted  = aborted_q;
  assign o_err      = err_q;
  assign o_err_addr = err_addr_q;

  assign o_awaddr   = addr_q;
  assign o_awid     = axi_id_t'(AxiId);
  assign o_awlen    = axi_len_t'(BurstLen - 1);
  assign o_awsize   = axi_size_of(DataWidth);
  assign o_awburst  = BURST_INCR;
  assign o_awvalid  = awvalid_q;

  assign o_wdata    = '0;
  assign o_wstrb    = '1;
  assign o_wlast    = wlast_q;
  assign o_wvalid   = wvalid_q;

  assign o_bready   = bready_q;

  assign o_araddr   = addr_q;
  assign o_arid     = axi_id_t'(AxiId);
  assign o_arlen    = axi_len_t'(BurstLen - 1);
  assign o_arsize   = axi_size_of(DataWidth);
  assign o_arburst  = BURST_INCR;
  assign o_arvalid  = arvalid_q;

  assign o_rready   = rready_q;

endmodule
